inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the queue entry count (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the program-counter width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-004 The block SHALL have parameter RESET_PC, default 32'hbfc00000, meaning the first fetch address after reset.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port instruction_enabled, output, 1 bit: SRAM read request this cycle.
REQ-008 The block SHALL have port instruction_address, output, ADDR_WIDTH bits: SRAM read address.
REQ-009 The block SHALL have port instruction_read_data, input, DATA_WIDTH bits: SRAM data, valid the cycle after a request.
REQ-010 The block SHALL have port redirect_valid, input, 1 bit: a branch/jump redirect from ID.
REQ-011 The block SHALL have port redirect_target, input, ADDR_WIDTH bits: the redirect address.
REQ-012 The block SHALL have port id_allow_in, input, 1 bit: ID accepts the head entry this cycle.
REQ-013 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-014 The block SHALL have port out_program_count, output, ADDR_WIDTH bits: PC of the head entry.
REQ-015 The block SHALL have port out_instruction, output, DATA_WIDTH bits: instruction of the head entry.
REQ-016 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: the number of valid entries.

Function
REQ-017 The block SHALL issue (instruction_enabled=1, instruction_address=fetch_pc) when redirect_valid=0 and occupancy+inflight < DEPTH, where inflight is 1 if a request was issued last cycle and not killed.
REQ-018 On issue, fetch_pc SHALL advance by 4, wrapping modulo 2^ADDR_WIDTH, and the issued PC SHALL be latched alongside the inflight flag.
REQ-019 When not issuing, instruction_enabled SHALL be 0 and instruction_address SHALL equal fetch_pc.
REQ-020 A non-killed response SHALL be written at the tail as {latched PC, instruction_read_data} in the cycle after issue.
REQ-021 The credit rule in REQ-017 guarantees a write is never dropped: no overflow is possible, and full with a pending write SHALL NOT occur.
REQ-022 out_valid SHALL be (occupancy != 0); out_program_count and out_instruction SHALL be driven from the head-entry storage, not from SRAM data combinationally.
REQ-023 The head SHALL be popped when out_valid=1, id_allow_in=1 and redirect_valid=0.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-026 Minimum latency SHALL be: issue in cycle N, entry written at the edge ending N+1, out_valid=1 in cycle N+2.
REQ-027 On redirect_valid=1, at the next edge the block SHALL empty all entries (occupancy=0), set fetch_pc to {redirect_target[ADDR_WIDTH-1:2], 2'b00}, and mark any response arriving next cycle as killed (not written).
REQ-028 No request SHALL issue in the redirect cycle.
REQ-029 Redirect SHALL take priority over pop, push and issue.
REQ-030 Back-to-back redirects SHALL each re-target; the last one wins.
REQ-031 With id_allow_in held 1 and no redirect, the block SHALL sustain one instruction per cycle in steady state.

Reset
REQ-032 While reset_=0 at a rising edge, the block SHALL set fetch_pc=RESET_PC, occupancy=0, inflight=0 and head=tail=0.
REQ-033 During reset, instruction_enabled SHALL be 0 and out_valid SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries and any in-flight response, identically to power-up.
REQ-035 The first issue SHALL occur in the first cycle with reset_=1, at address RESET_PC.

Verification
REQ-036 Release reset, id_allow_in=1 -> issues at bfc00000, bfc00004, ...; out_valid first high 2 cycles after the first issue; PCs in order, one per cycle.
REQ-037 id_allow_in=0 from reset, DEPTH=4 -> exactly 4 issues, occupancy saturates at 4, instruction_enabled stays 0; on id_allow_in=1 -> one pop per cycle and issue resumes.
REQ-038 Redirect to 00001003 while full with a request in flight -> next cycle occupancy=0 and the in-flight data is not written; the next issue is at 00001000; the old PCs never appear at the output.
REQ-039 fetch_pc=fffffffc -> the next issue is at 00000000 (wrap).
REQ-040 redirect_valid and a pop in the same cycle -> no pop is counted, queue emptied, occupancy=0.
REQ-041 Reset_ pulled low for 1 cycle mid-stream -> next cycle out_valid=0 and occupancy=0; the following issue is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : inst_fetch_queue                                              |
// | Brief    : Instruction fetch unit with a credit-controlled queue between |
// |            a one-cycle-latency SRAM and the decode stage. Redirects      |
// |            flush the queue and kill the response still in flight.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module inst_fetch_queue #(
  parameter int unsigned            DEPTH      = 4,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = 32'hbfc00000
) (
  input  logic                          clock,
  input  logic                          reset_,
  output logic                          instruction_enabled,
  output logic [ADDR_WIDTH-1:0]         instruction_address,
  input  logic [DATA_WIDTH-1:0]         instruction_read_data,
  input  logic                          redirect_valid,
  input  logic [ADDR_WIDTH-1:0]         redirect_target,
  input  logic                          id_allow_in,
  output logic                          out_valid,
  output logic [ADDR_WIDTH-1:0]         out_program_count,
  output logic [DATA_WIDTH-1:0]         out_instruction,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int unsigned     PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q,    fetch_pc_d;
  logic                  inflight_q,    inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]      head_q,        head_d;
  logic [PTR_W-1:0]      tail_q,        tail_d;
  logic [CNT_W-1:0]      count_q,       count_d;

  logic [ADDR_WIDTH-1:0] mem_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

  logic [CNT_W:0]        credit;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Handshake decisions: credit counts stored entries plus the response in
  // flight, so a queue slot is always reserved before a request goes out.
  always_comb begin
    credit = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    issue  = reset_ && !redirect_valid && (credit < DEPTH_C);
    push   = inflight_q && !redirect_valid;
    pop    = (count_q != '0) && id_allow_in && !redirect_valid;
  end

  // Next-state computation; a redirect overrides pop, push and issue.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (redirect_valid) begin
      // Word-align the target; emptying the queue just collapses head onto tail.
      fetch_pc_d = redirect_target & ~ADDR_WIDTH'(3);
      head_d     = tail_q;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
        inflight_pc_d = fetch_pc_q;
      end
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Entry storage: the surviving response lands at the tail with its PC.
  always_ff @(posedge clock) begin
    if (reset_ && push) begin
      mem_pc_q[tail_q]   <= inflight_pc_q;
      mem_data_q[tail_q] <= instruction_read_data;
    end
  end

  // Outputs come from registered state only, never straight from SRAM data.
  always_comb begin
    instruction_enabled = issue;
    instruction_address = fetch_pc_q;
    out_valid           = (count_q != '0);
    out_program_count   = mem_pc_q[head_q];
    out_instruction     = mem_data_q[head_q];
    occupancy           = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_inst_fetch_queue                                           |
// | Brief    : Self-checking bench for inst_fetch_queue with a queue-based   |
// |            reference model and a one-cycle SRAM model.                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;
  logic        instruction_enabled;
  logic [31:0] instruction_address;
  logic [31:0] instruction_read_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        id_allow_in = 1'b0;
  logic        out_valid;
  logic [31:0] out_program_count;
  logic [31:0] out_instruction;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  // reference model: queue of PCs, pending request, fetch PC
  logic [31:0] m_q[$], n_q[$];
  bit          m_pend, n_pend = 1'b0;
  logic [31:0] m_pend_pc, n_pend_pc = 32'h0;
  logic [31:0] m_fpc, n_fpc = 32'h0;

  bit          e_en, e_valid;
  logic [31:0] e_addr, e_pc, e_ins;
  int          e_occ;

  inst_fetch_queue #(
    .DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(RST_PC)
  ) dut (
    .clock                 (clock),
    .reset_                (reset_),
    .instruction_enabled   (instruction_enabled),
    .instruction_address   (instruction_address),
    .instruction_read_data (instruction_read_data),
    .redirect_valid        (redirect_valid),
    .redirect_target       (redirect_target),
    .id_allow_in           (id_allow_in),
    .out_valid             (out_valid),
    .out_program_count     (out_program_count),
    .out_instruction       (out_instruction),
    .occupancy             (occupancy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] h(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h13579bdf;
  endfunction

  // SRAM: data for the requested address appears the following cycle
  always @(posedge clock)
    instruction_read_data <= instruction_enabled ? h(instruction_address) : 32'hdeadbeef;

  // Drive one cycle of inputs and compute what the DUT should show now.
  task automatic step(input bit rn, input bit rd, input logic [31:0] tgt, input bit allow);
    @(negedge clock);
    m_q = n_q; m_pend = n_pend; m_pend_pc = n_pend_pc; m_fpc = n_fpc;
    reset_ = rn; redirect_valid = rd; redirect_target = tgt; id_allow_in = allow;
    #1;
    e_occ   = m_q.size();
    e_valid = (e_occ != 0);
    e_pc    = e_valid ? m_q[0] : 32'h0;
    e_ins   = h(e_pc);
    e_addr  = m_fpc;
    e_en    = rn && !rd && (e_occ + int'(m_pend) < DEPTH);
    n_q = m_q; n_pend = m_pend; n_pend_pc = m_pend_pc; n_fpc = m_fpc;
    if (!rn) begin
      n_q.delete(); n_pend = 1'b0; n_fpc = RST_PC;
    end else if (rd) begin
      n_q.delete(); n_pend = 1'b0; n_fpc = {tgt[31:2], 2'b00};
    end else begin
      if (e_valid && allow) void'(n_q.pop_front());
      if (m_pend) n_q.push_back(m_pend_pc);
      n_pend    = e_en;
      n_pend_pc = m_fpc;
      if (e_en) n_fpc = m_fpc + 32'd4;
    end
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    total++; if (instruction_enabled !== 1'b0) begin bad++; $display("FAIL reset_en got %b want 0", instruction_enabled); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    total++; if (instruction_address !== RST_PC) begin bad++; $display("FAIL reset_pc got %h want %h", instruction_address, RST_PC); end
  endtask

  task automatic test_stream();
    step(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 1);
      total++;
      if ({instruction_enabled, instruction_address, out_valid, occupancy} !== {e_en, e_addr, e_valid, e_occ[2:0]}) begin
        bad++; $display("FAIL stream_ctl cyc=%0d got en=%b a=%h v=%b o=%0d want en=%b a=%h v=%b o=%0d",
          i, instruction_enabled, instruction_address, out_valid, occupancy, e_en, e_addr, e_valid, e_occ);
      end
      if (i == 0) begin
        total++; if ({instruction_enabled, instruction_address} !== {1'b1, RST_PC}) begin
          bad++; $display("FAIL stream_first_issue got %b/%h want 1/%h", instruction_enabled, instruction_address, RST_PC); end
      end
      if (i == 1) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid got %b want 0", out_valid); end
      end
      if (i >= 2) begin
        total++; if ({out_valid, out_program_count, out_instruction} !== {1'b1, RST_PC + 32'(4*(i-2)), h(RST_PC + 32'(4*(i-2)))}) begin
          bad++; $display("FAIL stream_head cyc=%0d got v=%b pc=%h ins=%h want pc=%h", i, out_valid, out_program_count, out_instruction, RST_PC + 32'(4*(i-2))); end
      end
    end
  endtask

  task automatic test_fill();
    int issues = 0;
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0);
      issues += int'(instruction_enabled);
    end
    total++; if (issues !== 4) begin bad++; $display("FAIL fill_issues got %0d want 4", issues); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL fill_occ got %0d want 4", occupancy); end
    total++; if (instruction_enabled !== 1'b0) begin bad++; $display("FAIL fill_en got %b want 0", instruction_enabled); end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1);
      total++;
      if ({instruction_enabled, out_valid, occupancy, out_program_count} !== {e_en, e_valid, e_occ[2:0], e_pc}) begin
        bad++; $display("FAIL drain cyc=%0d got en=%b v=%b o=%0d pc=%h want en=%b v=%b o=%0d pc=%h",
          i, instruction_enabled, out_valid, occupancy, out_program_count, e_en, e_valid, e_occ, e_pc);
      end
    end
  endtask

  task automatic test_redirect_full();
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 1, 32'h00001003, 0);
    total++; if ({occupancy, instruction_enabled} !== {3'd3, 1'b0}) begin
      bad++; $display("FAIL redir_pre got occ=%0d en=%b want occ=3 en=0", occupancy, instruction_enabled); end
    step(1, 0, 0, 1);
    total++; if ({occupancy, out_valid, instruction_enabled, instruction_address} !== {3'd0, 1'b0, 1'b1, 32'h00001000}) begin
      bad++; $display("FAIL redir_post got occ=%0d v=%b en=%b a=%h want occ=0 v=0 en=1 a=00001000",
        occupancy, out_valid, instruction_enabled, instruction_address); end
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 1);
      if (i == 1) begin
        total++; if ({out_valid, out_program_count} !== {1'b1, 32'h00001000}) begin
          bad++; $display("FAIL redir_first_head got v=%b pc=%h want 1/00001000", out_valid, out_program_count); end
      end
      if (out_valid === 1'b1) begin
        total++; if (out_program_count[31:8] !== 24'h000010) begin
          bad++; $display("FAIL redir_stale_pc got %h want 000010xx", out_program_count); end
      end
    end
  endtask

  task automatic test_wrap();
    step(1, 1, 32'hfffffffc, 1);
    step(1, 0, 0, 1);
    total++; if ({instruction_enabled, instruction_address} !== {1'b1, 32'hfffffffc}) begin
      bad++; $display("FAIL wrap_a got %b/%h want 1/fffffffc", instruction_enabled, instruction_address); end
    step(1, 0, 0, 1);
    total++; if ({instruction_enabled, instruction_address} !== {1'b1, 32'h00000000}) begin
      bad++; $display("FAIL wrap_b got %b/%h want 1/00000000", instruction_enabled, instruction_address); end
  endtask

  task automatic test_redirect_pop();
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    step(1, 1, 32'h00002000, 1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rpop_pre_valid got %b want 1", out_valid); end
    step(1, 0, 0, 1);
    total++; if ({occupancy, out_valid, instruction_address} !== {3'd0, 1'b0, 32'h00002000}) begin
      bad++; $display("FAIL rpop_post got occ=%0d v=%b a=%h want 0/0/00002000", occupancy, out_valid, instruction_address); end
  endtask

  task automatic test_mid_reset();
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    total++; if (instruction_enabled !== 1'b0) begin bad++; $display("FAIL mreset_en got %b want 0", instruction_enabled); end
    step(1, 0, 0, 1);
    total++; if ({out_valid, occupancy, instruction_enabled, instruction_address} !== {1'b0, 3'd0, 1'b1, RST_PC}) begin
      bad++; $display("FAIL mreset_post got v=%b o=%0d en=%b a=%h want 0/0/1/%h",
        out_valid, occupancy, instruction_enabled, instruction_address, RST_PC); end
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    total++; if ({out_valid, out_program_count} !== {1'b1, RST_PC}) begin
      bad++; $display("FAIL mreset_head got v=%b pc=%h want 1/%h", out_valid, out_program_count, RST_PC); end
  endtask

  task automatic test_random();
    bit          rn, rd, allow;
    logic [31:0] tgt;
    step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      rn    = ($urandom_range(0, 49) != 0);
      rd    = ($urandom_range(0, 9) == 0);
      allow = ($urandom_range(0, 2) != 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 | ($urandom & 32'hf)) : 32'($urandom);
      step(rn, rd, tgt, allow);
      total++;
      if ({instruction_enabled, instruction_address, out_valid, occupancy} !== {e_en, e_addr, e_valid, e_occ[2:0]}) begin
        bad++; $display("FAIL rand_ctl cyc=%0d got en=%b a=%h v=%b o=%0d want en=%b a=%h v=%b o=%0d",
          i, instruction_enabled, instruction_address, out_valid, occupancy, e_en, e_addr, e_valid, e_occ);
      end
      if (e_valid) begin
        total++;
        if ({out_program_count, out_instruction} !== {e_pc, e_ins}) begin
          bad++; $display("FAIL rand_head cyc=%0d got pc=%h ins=%h want pc=%h ins=%h",
            i, out_program_count, out_instruction, e_pc, e_ins);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect_full();
    test_wrap();
    test_redirect_pop();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
